// File: rtl/des_pkg.sv
// Shared constants and helpers for the DES key schedule: PC-1/PC-2 tables,
// the per-round shift schedule and the FSM state type.
// All bit vectors use FIPS 46-3 numbering: FIPS bit n of a W-bit vector sits
// at index [W+1-n] of a [W:1] vector, i.e. FIPS bit 1 is the MSB.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ks_state_e;

  // PC-1: entry i is the key bit (1..64) that becomes CD bit i+1
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i is the CD bit (1..56) that becomes subkey bit i+1
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT schedule: bit r set means round r rotates by 2, else by 1
  localparam logic [16:1] SHIFT_TWO = 16'b0111_1110_1111_1100;

  function automatic logic [1:0] shift_amt(input logic [4:0] r);
    return SHIFT_TWO[r] ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [CD_W:1] pc1(input logic [KEY_W:1] key);
    logic [CD_W:1] r;
    r = '0;
    for (int unsigned i = 0; i < CD_W; i++)
      r[6'(CD_W - i)] = key[7'(KEY_W + 1 - PC1_TAB[6'(i)])];
    return r;
  endfunction

  function automatic logic [SUBKEY_W:1] pc2(input logic [CD_W:1] cd);
    logic [SUBKEY_W:1] r;
    r = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++)
      r[6'(SUBKEY_W - i)] = cd[6'(CD_W + 1 - PC2_TAB[6'(i)])];
    return r;
  endfunction

  // Flags any key byte whose parity is even (DES expects odd parity)
  function automatic logic parity_err(input logic [KEY_W:1] key);
    logic e;
    e = 1'b0;
    for (int unsigned b = 0; b < 8; b++)
      e = e | ~(^key[7'(8 * b + 1) +: 8]);
    return e;
  endfunction

endpackage

// File: rtl/des_cd_rotate.sv
// Combinational rotator for the C and D halves of the DES key schedule.
// One instance serves both halves so they always rotate identically.
// Ports:
//   c, d       28-bit halves, [28:1] with bit 28 = FIPS bit 1
//   amount     rotation amount, 1 or 2
//   dir_right  0 = rotate left {x[27:1],x[28]}, 1 = rotate right
//   c_rot_c    rotated C
//   d_rot_c    rotated D
module des_cd_rotate
  import des_pkg::*;
(
  input  logic [HALF_W:1] c,
  input  logic [HALF_W:1] d,
  input  logic [1:0]      amount,
  input  logic            dir_right,
  output logic [HALF_W:1] c_rot_c,
  output logic [HALF_W:1] d_rot_c
);

  logic two;

  assign two = (amount == 2'd2);

  function automatic logic [HALF_W:1] rot(input logic [HALF_W:1] x,
                                          input logic             by_two,
                                          input logic             right);
    logic [HALF_W:1] r;
    case ({right, by_two})
      2'b00:   r = {x[27:1], x[28]};
      2'b01:   r = {x[26:1], x[28:27]};
      2'b10:   r = {x[1],    x[28:2]};
      default: r = {x[2:1],  x[28:3]};
    endcase
    return r;
  endfunction

  assign c_rot_c = rot(c, two, dir_right);
  assign d_rot_c = rot(d, two, dir_right);

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into 16 48-bit round subkeys,
// presented one per cycle over a valid/ready handshake.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN adds the decrypt port and
// reverse-order (K16..K1) generation via right rotation.
// Parameter PARITY_CHECK: nonzero enables odd-parity checking of key bytes.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, key_in  expansion request and key, sampled only in IDLE
//   decrypt        reverse order request, sampled with start (macro only)
//   busy           high while a sequence is in ROUND or DONE
//   subkey_valid   subkey/round_idx hold a round key
//   subkey_ready   downstream accepts when valid && ready
//   subkey         PC-2 output, FIPS bit n at subkey[49-n]
//   round_idx      position 0..15 of the subkey in the emitted sequence
//   done           one-cycle pulse after the 16th subkey is accepted
//   key_err        registered parity error for the last started key
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned PARITY_CHECK = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_W:1]      key_in,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic                decrypt,
`endif
  output logic                busy,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [SUBKEY_W:1]   subkey,
  output logic [IDX_W:1]      round_idx,
  output logic                done,
  output logic                key_err
);

  ks_state_e          state_q, state_d;
  logic [HALF_W:1]    c_q, d_q, c_d, d_d;
  logic [SUBKEY_W:1]  subkey_d;
  logic [IDX_W:1]     idx_d;
  logic               valid_d, done_d, busy_d, key_err_d;
  logic [CD_W:1]      key_cd;
  logic [HALF_W:1]    rot_c_in, rot_d_in, c_rot_c, d_rot_c;
  logic [1:0]         rot_amt;
  logic               rot_right;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic               dec_q, dec_d;
`endif

  assign key_cd = pc1(key_in);

  // Rotator feed: PC-1 of the incoming key in IDLE, else the held C/D
  always_comb begin
    rot_c_in  = key_cd[56:29];
    rot_d_in  = key_cd[28:1];
    rot_amt   = shift_amt(5'd1);
    rot_right = 1'b0;
    if (state_q != IDLE) begin
      rot_c_in = c_q;
      rot_d_in = d_q;
      rot_amt  = shift_amt(5'(round_idx) + 5'd2);
`ifdef DES_KEYSCHED_DECRYPT_EN
      // Walking back from C16=C0: output r>=2 undoes round 18-r
      if (dec_q) begin
        rot_right = 1'b1;
        rot_amt   = shift_amt(5'd16 - 5'(round_idx));
      end
`endif
    end
  end

  des_cd_rotate u_rotate (
    .c         (rot_c_in),
    .d         (rot_d_in),
    .amount    (rot_amt),
    .dir_right (rot_right),
    .c_rot_c   (c_rot_c),
    .d_rot_c   (d_rot_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    subkey_d  = subkey;
    idx_d     = round_idx;
    valid_d   = subkey_valid;
    done_d    = 1'b0;
    key_err_d = key_err;
`ifdef DES_KEYSCHED_DECRYPT_EN
    dec_d     = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d = c_rot_c;
          d_d = d_rot_c;
`ifdef DES_KEYSCHED_DECRYPT_EN
          // K16 is PC-2 of the unrotated halves
          dec_d = decrypt;
          if (decrypt) begin
            c_d = key_cd[56:29];
            d_d = key_cd[28:1];
          end
`endif
          subkey_d  = pc2({c_d, d_d});
          idx_d     = '0;
          valid_d   = 1'b1;
          key_err_d = (PARITY_CHECK != 0) && parity_err(key_in);
          state_d   = ROUND;
        end
      end
      ROUND: begin
        if (subkey_ready) begin
          if (round_idx == 4'd15) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            c_d      = c_rot_c;
            d_d      = d_rot_c;
            subkey_d = pc2({c_rot_c, d_rot_c});
            idx_d    = round_idx + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      d_q          <= '0;
      subkey       <= '0;
      round_idx    <= '0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      key_err      <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
      dec_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      d_q          <= d_d;
      subkey       <= subkey_d;
      round_idx    <= idx_d;
      subkey_valid <= valid_d;
      done         <= done_d;
      busy         <= busy_d;
      key_err      <= key_err_d;
`ifdef DES_KEYSCHED_DECRYPT_EN
      dec_q        <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: a default instance and a
// PARITY_CHECK=1 instance share stimulus; subkeys are compared against a
// table-driven reference schedule built from 64-bit integer arithmetic.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [64:1] key_in = '0;
  logic        subkey_ready = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        decrypt = 1'b0;
`endif
  logic        busy, subkey_valid, done, key_err;
  logic [48:1] subkey;
  logic [4:1]  round_idx;
  logic        p_busy, p_valid, p_done, p_key_err;
  logic [48:1] p_subkey;
  logic [4:1]  p_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] exp_k [16];
  logic [47:0] obs_k [16];
  logic [47:0] norot_k;

  localparam logic [63:0] GOLD_KEY = 64'h1334_5779_9BBC_DFF1;

  int unsigned PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                            10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                            63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                            14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int unsigned PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                            23,19,12,4,26,8, 16,7,27,20,13,2,
                            41,52,31,37,47,55, 30,40,51,45,33,48,
                            44,49,39,56,34,53, 46,42,50,36,29,32};

  always #5 clk = ~clk;

  des_key_schedule #(.PARITY_CHECK(0)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round_idx(round_idx), .done(done), .key_err(key_err)
  );

  des_key_schedule #(.PARITY_CHECK(1)) dut_par (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .busy(p_busy), .subkey_valid(p_valid), .subkey_ready(subkey_ready),
    .subkey(p_subkey), .round_idx(p_idx), .done(p_done), .key_err(p_key_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rotl28(input int unsigned x, input int unsigned s);
    return ((x << s) | (x >> (28 - s))) & 32'h0FFF_FFFF;
  endfunction

  function automatic logic [47:0] m_pc2(input int unsigned c, input int unsigned d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c[27:0], d[27:0]};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56 - PC2[i]];
    return r;
  endfunction

  function automatic logic m_par_err(input logic [63:0] key);
    logic e = 1'b0;
    for (int b = 0; b < 8; b++)
      if (($countones(key[8*b +: 8]) % 2) == 0) e = 1'b1;
    return e;
  endfunction

  // Reference schedule: cumulative left rotations, reversed for decrypt
  task automatic build_model(input logic [63:0] key, input bit dec);
    logic [55:0] cd0;
    logic [47:0] enc [16];
    int unsigned c, d, s;
    for (int i = 0; i < 56; i++) cd0[55-i] = key[64 - PC1[i]];
    c = 32'(cd0[55:28]);
    d = 32'(cd0[27:0]);
    norot_k = m_pc2(c, d);
    for (int r = 1; r <= 16; r++) begin
      s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      c = rotl28(c, s);
      d = rotl28(d, s);
      enc[r-1] = m_pc2(c, d);
    end
    for (int i = 0; i < 16; i++) exp_k[i] = dec ? enc[15-i] : enc[i];
  endtask

  // mode: 0 ready=1, 1 random ready + start in DONE, 2 stall at idx 3,
  //       3 second start at idx 5, 4 reset at idx 7
  task automatic expand(input logic [63:0] key, input bit dec, input int mode);
    int  n = 0;
    int  stall = 0;
    bit  fin = 1'b0;
    bit  sent2 = 1'b0;
    bit  rdy;
    build_model(key, dec);
    key_in = key;
    start = 1'b1;
    subkey_ready = 1'b1;
`ifdef DES_KEYSCHED_DECRYPT_EN
    decrypt = dec;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom};
    check("first_valid", 64'(subkey_valid), 64'd1);
    check("key_err_off", 64'(key_err), 64'd0);
    check("key_err_par", 64'(p_key_err), 64'(m_par_err(key)));
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      check("valid", 64'(subkey_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("done_low", 64'(done), 64'd0);
      check("round_idx", 64'(round_idx), 64'(n));
      check("subkey", 64'(subkey), 64'(exp_k[n]));
      obs_k[n] = subkey;
      if ((!dec && n == 15) || (dec && n == 0))
        check("k16_c16_eq_c0", 64'(subkey), 64'(norot_k));
      if (mode == 4 && n == 7) begin
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_idx", 64'(round_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("rst_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        return;
      end
      case (mode)
        1: rdy = ($urandom_range(0, 2) != 0);
        2: if (n == 3 && stall < 5) begin rdy = 1'b0; stall++; end else rdy = 1'b1;
        default: rdy = 1'b1;
      endcase
      subkey_ready = rdy;
      start = 1'b0;
      if (mode == 3 && n == 5 && !sent2) begin
        start = 1'b1;
        key_in = ~key;
        sent2 = 1'b1;
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (n == 15) fin = 1'b1;
        else n++;
      end
    end
    start = 1'b0;
    check("seq_complete", 64'(fin), 64'd1);
    check("done_pulse", 64'(done), 64'd1);
    check("done_valid_low", 64'(subkey_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd1);
    if (mode == 1) begin
      start = 1'b1;
      key_in = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_cleared", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rkey;
    bit          rdec;
    #2 rst = 1'b1;
    #1;
    check("reset_valid", 64'(subkey_valid), 64'd0);
    check("reset_subkey", 64'(subkey), 64'd0);
    check("reset_idx", 64'(round_idx), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_key_err", 64'(p_key_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    expand(GOLD_KEY, 1'b0, 0);
    check("gold_k1", 64'(obs_k[0]), 64'h1B02EFFC7072);
    check("gold_k2", 64'(obs_k[1]), 64'h79AED9DBC9E5);
    check("gold_k16", 64'(obs_k[15]), 64'hCB3D8B0E17F5);

`ifdef DES_KEYSCHED_DECRYPT_EN
    expand(GOLD_KEY, 1'b1, 0);
    check("dec_first", 64'(obs_k[0]), 64'hCB3D8B0E17F5);
    check("dec_last", 64'(obs_k[15]), 64'h1B02EFFC7072);
`endif

    expand(GOLD_KEY, 1'b0, 2);
    check("bp_k1", 64'(obs_k[0]), 64'h1B02EFFC7072);
    check("bp_k16", 64'(obs_k[15]), 64'hCB3D8B0E17F5);

    expand(GOLD_KEY, 1'b0, 3);
    check("sb_k16", 64'(obs_k[15]), 64'hCB3D8B0E17F5);

    expand(GOLD_KEY, 1'b0, 4);
    expand(GOLD_KEY, 1'b0, 0);
    check("post_rst_k1", 64'(obs_k[0]), 64'h1B02EFFC7072);

    expand(64'h0, 1'b0, 0);
    expand(64'h0101_0101_0101_0101, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      rkey = {$urandom, $urandom};
      rdec = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
      rdec = 1'($urandom_range(0, 1));
`endif
      expand(rkey, rdec, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have parameter PARITY_CHECK, default 0, meaning 1 enables odd-parity checking of each key byte.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to expand key_in; sampled only in IDLE.
REQ-005 The block SHALL have port key_in, input, [64:1]: key with FIPS 46-3 bit n at key_in[65-n]; sampled only in IDLE.
REQ-006 The block SHALL have port decrypt, input, 1 bit: sampled with start; 1 emits K16..K1 (present only with DES_KEYSCHED_DECRYPT_EN).
REQ-007 The block SHALL have port busy, output, 1 bit: high in ROUND and DONE.
REQ-008 The block SHALL have port subkey_valid, output, 1 bit: subkey holds a valid round key.
REQ-009 The block SHALL have port subkey_ready, input, 1 bit: downstream accepts the subkey when valid && ready.
REQ-010 The block SHALL have port subkey, output, [48:1]: PC-2 output, FIPS bit n at subkey[49-n].
REQ-011 The block SHALL have port round_idx, output, [4:1]: index 0..15 of the subkey presented; KEY number = round_idx+1 (encrypt) or 16-round_idx (decrypt).
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the 16th subkey is accepted.
REQ-013 The block SHALL have port key_err, output, 1 bit: registered parity error flag; tied 0 when PARITY_CHECK=0.

Function
REQ-014 FSM states SHALL be IDLE, ROUND and DONE.
REQ-015 IDLE with start=1 SHALL load C/D = PC-1(key_in), with C = the upper 28 bits as [28:1], and go to ROUND.
REQ-016 The first subkey_valid SHALL assert on the cycle after start is sampled, giving a latency of 1 cycle.
REQ-017 Encrypt round r (1..16) SHALL rotate C and D left, in the sense {x[27:1],x[28]}, by SHIFT[r] before applying PC-2.
REQ-018 SHIFT SHALL equal 1 for r = 1, 2, 9, 16 and 2 otherwise.
REQ-019 Rotation and PC-2 SHALL be registered, so subkey is a flop output.
REQ-020 While subkey_valid && !subkey_ready, subkey, round_idx, C and D SHALL hold stable.
REQ-021 The next round SHALL compute on the acceptance edge, giving one subkey per cycle under continuous ready.
REQ-022 Acceptance at round_idx=15 SHALL deassert subkey_valid, go to DONE and pulse done, then return to IDLE on the next cycle.
REQ-023 start while busy SHALL be ignored, and key_in changes while busy SHALL have no effect.
REQ-024 start in the DONE cycle SHALL be ignored.
REQ-025 After 16 rounds, total rotation SHALL be 28, so C16/D16 equal C0/D0; a bench SHALL check this.

Reset
REQ-026 rst SHALL force IDLE, subkey_valid=0, subkey=0, round_idx=0, done=0, busy=0, key_err=0 and C/D=0, asynchronously.
REQ-027 Reset mid-sequence SHALL abandon the sequence with no done pulse.
REQ-028 Operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-029 The block SHALL use macro DES_KEYSCHED_DECRYPT_EN.
REQ-030 With DES_KEYSCHED_DECRYPT_EN defined, decrypt=1 SHALL emit K16 first, as PC-2(C0,D0) with no rotation.
REQ-031 With DES_KEYSCHED_DECRYPT_EN defined, decrypt output r≥2 SHALL first rotate right by SHIFT[18-r].
REQ-032 Without DES_KEYSCHED_DECRYPT_EN, the decrypt port SHALL be absent and the block encrypt-only, with no right-rotate logic.

Structure
REQ-033 Package des_pkg SHALL hold the PC1 and PC2 tables, the SHIFT schedule constant and the FSM state typedef.
REQ-034 Sub-module des_cd_rotate SHALL be combinational and take a 28-bit C and D, amount 1/2, and a direction.
REQ-035 des_cd_rotate SHALL be instantiated once and shared by C and D.

Verification
REQ-036 Encrypt test: key 0x133457799BBCDFF1, start, ready=1 -> K1=0x1B02EFFC7072 at round_idx 0, K2=0x79AED9DBC9E5 next cycle, K16=0xCB3D8B0E17F5 at round_idx 15, done exactly 1 cycle later.
REQ-037 Decrypt test: same key with decrypt=1 (macro on) -> first subkey 0xCB3D8B0E17F5, last 0x1B02EFFC7072.
REQ-038 Backpressure test: ready low for 5 cycles at round_idx 3 -> subkey and round_idx frozen; sequence completes with the same 16 values.
REQ-039 Reset test: rst pulsed at round_idx 7 -> all outputs 0 immediately, no done pulse; a new start yields K1 again.
REQ-040 Start-while-busy test: second start with a different key at round_idx 5 -> ignored, and the original sequence is unchanged.
REQ-041 Parity test: PARITY_CHECK=1, key 0x0000000000000000 -> key_err=1 the cycle after start; key 0x0101010101010101 -> key_err=0.
